// File: rtl/hs_pkg.sv
// Shared constants and helpers for the handshake byte packers.
// Default lane count and counter-width function used by handshake_pack4.
package hs_pkg;

  localparam int LANES_DEF = 4;

  // Width of a lane counter holding 0..lanes-1; never narrower than one bit.
  function automatic int cnt_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/handshake_pack4.sv
// Packs LANES bytes (lane 0 first) into one word; word valid 1 cycle after its last byte.
// Only the word-closing byte stalls on a held word; HS_PACK_LAST_EN adds last/keep for short words.
module handshake_pack4
  import hs_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_pre_i,
  input  logic [7:0]           data_pre_i,
  output logic                 ready_pre_o,
  output logic                 valid_post_o,
  output logic [8*LANES-1:0]   data_post_o,
`ifdef HS_PACK_LAST_EN
  input  logic                 last_pre_i,
  output logic                 last_post_o,
  output logic [LANES-1:0]     keep_post_o,
`endif
  input  logic                 ready_post_i
);

  localparam int CW = cnt_w(LANES);

  logic [CW-1:0]        r_cnt;
  logic [8*LANES-1:0]   r_asm;
  logic [8*LANES-1:0]   r_data;
  logic                 r_vld;
  logic                 w_last_lane;
  logic                 w_close;
  logic                 w_ready;
  logic                 w_acc;
  logic                 w_xfer;
  logic [8*LANES-1:0]   w_word;

  assign w_last_lane = (r_cnt == CW'(LANES - 1));

`ifdef HS_PACK_LAST_EN
  logic [LANES-1:0]     r_keep;
  logic                 r_last;
  logic [LANES-1:0]     w_keep;

  assign w_close = w_last_lane || last_pre_i;
`else
  assign w_close = w_last_lane;
`endif

  // Stall only the byte that would overwrite a word still waiting downstream.
  assign w_ready = !w_close || !r_vld || ready_post_i;
  assign w_acc   = valid_pre_i && w_ready;
  assign w_xfer  = r_vld && ready_post_i;

  // Completed word as it will look once the current byte lands in its lane.
  always_comb begin
    w_word = r_asm;
`ifdef HS_PACK_LAST_EN
    w_keep = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      if (i == int'(r_cnt)) begin
        w_word[8*i +: 8] = data_pre_i;
      end
`ifdef HS_PACK_LAST_EN
      if (i > int'(r_cnt)) begin
        w_word[8*i +: 8] = 8'h00;
      end
      w_keep[i] = (i <= int'(r_cnt));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_asm  <= '0;
      r_data <= '0;
      r_vld  <= 1'b0;
`ifdef HS_PACK_LAST_EN
      r_keep <= '0;
      r_last <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_asm[8*int'(r_cnt) +: 8] <= data_pre_i;
        r_cnt <= w_close ? '0 : r_cnt + 1'b1;
      end
      // A load in the same cycle as a transfer keeps valid high with the new word.
      if (w_acc && w_close) begin
        r_data <= w_word;
        r_vld  <= 1'b1;
`ifdef HS_PACK_LAST_EN
        r_keep <= w_keep;
        r_last <= last_pre_i;
`endif
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign ready_pre_o  = w_ready;
  assign valid_post_o = r_vld;
  assign data_post_o  = r_data;
`ifdef HS_PACK_LAST_EN
  assign last_post_o  = r_last;
  assign keep_post_o  = r_keep;
`endif

endmodule
